multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multi-cycle RV32I core. It is the Moore FSM directly upstream of the unified instruction/data memory: it sequences fetch, decode, address generation, memory access and writeback, and it drives the memory's address-source select and write enable. It also generates the ALU, immediate and result mux controls, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter `instret`

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
op  in  7  instruction[6:0] from instruction register
funct3  in  3  instruction[14:12]
funct7b5  in  1  instruction[30]
zero  in  1  ALU zero flag (current cycle)
pc_write  out  1  PC register load enable
adr_src  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  memory write enable
ir_write  out  1  instruction register (and OldPC) load enable
reg_write  out  1  register file write enable
result_src  out  2  00=ALUOut, 01=Data reg, 10=ALUResult
alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 reg
alu_src_b  out  2  00=rs2 reg, 01=ImmExt, 10=constant 4
imm_src  out  2  00=I, 01=S, 10=B, 11=J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instret  out  CNT_W  retired-instruction count
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset: the reset is synchronous and active-low. A rising edge of clk with rst_n=0 puts the FSM in FETCH and sets instret=0. While rst_n=0, pc_write, ir_write, mem_write and reg_write are forced to 0. Reset asserted mid-instruction abandons that instruction and does not increment instret.
- Outputs are Moore outputs decoded from the state, with three exceptions: imm_src (from op), alu_control (from ALUOp/funct), and pc_write in BEQ.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, ALUOp=00, result_src=10, pc_write=1 -> DECODE.
  - DECODE: a=01, b=01, ALUOp=00 (precomputes branch target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> FETCH
  - MEMADR: a=10, b=01, ALUOp=00. op=0000011 -> MEMREAD; otherwise -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00 -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 -> FETCH.
  - EXECUTER: a=10, b=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: a=10, b=01, ALUOp=10 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - JAL: a=01, b=10, ALUOp=00, result_src=00, pc_write=1 -> ALUWB.
  - BEQ: a=10, b=00, ALUOp=01, result_src=00, pc_write=zero -> FETCH.
- imm_src by op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct3:
    - 000 -> sub if op[5]&funct7b5, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - others -> add
  - ALUOp 11 -> add.
- instret increments by 1 on every clock edge where the state leaves MEMWB, MEMWRITE, ALUWB or BEQ, or leaves DECODE for FETCH. Wraps modulo 2^CNT_W.
- Latencies: lw 5 cycles; sw 4; R/I-type 4; jal 4; beq 3.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- When defined:
  - adds output illegal_insn (1 bit) and state TRAP.
  - An unrecognised op in DECODE moves the FSM to TRAP.
  - TRAP holds forever with all enables 0 and illegal_insn=1, and does not increment instret.
  - Only reset exits TRAP; illegal_insn resets to 0.
- When not defined: an unrecognised op in DECODE returns to FETCH, is counted as retired (nop), and the port is absent.

Decomposition:
- Package rv32_mc_pkg holds:
  - state enum (4-bit)
  - ALUOp codes
  - opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL)
  - alu_control codes
  - mux select encodings for result_src, alu_src_a, alu_src_b and imm_src
- Sub-module alu_decoder: combinational {ALUOp, funct3, op[5], funct7b5} -> alu_control, instantiated once.

Test Plan:
- rst_n=0 for 2 cycles then 1 -> state_o=FETCH, instret=0, all enables 0 during reset; pc_write=1 and ir_write=1 on the first post-reset cycle.
- Program "sw x1,4(x2)" (op=0100011):
  - visits FETCH, DECODE, MEMADR, MEMWRITE.
  - mem_write=1 with adr_src=1 only in cycle 4, imm_src=01.
  - instret becomes 1 after cycle 4.
- "lw x13,4(x2)" (op=0000011):
  - 5-cycle sequence ending in MEMWB.
  - reg_write=1 and result_src=01 only in cycle 5.
  - instret becomes 2 after the sw+lw pair.
- R-type, funct3=000, funct7b5=1 -> alu_control=001 in EXECUTER.
- Same instruction with funct7b5=0 -> alu_control=000.
- addi (op=0010011, funct7b5=1) -> alu_control=000.
- beq with zero=1 -> pc_write=1 in cycle 3; with zero=0 -> pc_write=0. Both take 3 cycles and increment instret.
- op=1111111 -> with MC_ILLEGAL_TRAP_EN: TRAP, illegal_insn=1, instret frozen, exit only on reset. Without the macro: FETCH after DECODE, instret+1.
- Reset asserted during MEMADR -> FETCH next cycle, mem_write never pulses, instret unchanged.

Source files
------------

// File: rtl/rv32_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, ALUOp codes, opcodes, ALU control codes and datapath mux selects.
package rv32_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for a state; BEQ's conditional PC load is added by the top.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_SUB;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction funct fields.
module alu_decoder
    import rv32_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // op5 separates R-type sub from I-type addi, which has no subtract form.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multi-cycle RV32I core with retired-instruction counter.
// Optional MC_ILLEGAL_TRAP_EN adds a sticky TRAP state and the illegal_insn output.
module multicycle_controller
    import rv32_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic [CNT_W-1:0] instret,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic             illegal_insn,
`endif
    output logic [3:0]       state_o
);

    state_t           state_r;
    state_t           next_s;
    ctrl_t            ctrl_r;
    logic [CNT_W-1:0] instret_r;
    logic             retire_s;
`ifdef MC_ILLEGAL_TRAP_EN
    logic             illegal_r;
`endif

    // Next-state decode.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_RTYPE:     next_s = S_EXECUTER;
                    OP_ITYPE:     next_s = S_EXECUTEI;
                    OP_BEQ:       next_s = S_BEQ;
                    OP_JAL:       next_s = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      next_s = S_TRAP;
`else
                    default:      next_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_s = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_s = S_MEMWB;
            S_EXECUTER: next_s = S_ALUWB;
            S_EXECUTEI: next_s = S_ALUWB;
            S_JAL:      next_s = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     next_s = S_TRAP;
`endif
            default:    next_s = S_FETCH;
        endcase
    end

    // An instruction retires when its last state is left (DECODE->FETCH is a nop).
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire_s = 1'b1;
            S_DECODE: retire_s = (next_s == S_FETCH);
            default:  retire_s = 1'b0;
        endcase
    end

    // State, registered control word for the incoming state, and instret.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            ctrl_r    <= state_ctrl(S_FETCH);
            instret_r <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            state_r <= next_s;
            ctrl_r  <= state_ctrl(next_s);
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1);
            end else begin
                instret_r <= instret_r;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_r <= (next_s == S_TRAP);
`endif
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_r.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    // Enables are gated by rst_n so nothing writes while reset is held.
    assign pc_write   = rst_n & (ctrl_r.pc_write | ((state_r == S_BEQ) & zero));
    assign ir_write   = rst_n & ctrl_r.ir_write;
    assign mem_write  = rst_n & ctrl_r.mem_write;
    assign reg_write  = rst_n & ctrl_r.reg_write;
    assign adr_src    = ctrl_r.adr_src;
    assign result_src = ctrl_r.result_src;
    assign alu_src_a  = ctrl_r.alu_src_a;
    assign alu_src_b  = ctrl_r.alu_src_b;
    assign imm_src    = imm_sel(op);
    assign instret    = instret_r;
    assign state_o    = state_r;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_insn = illegal_r;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus random instruction stream
// compared against an instruction-level model of latency, enables and instret.
module tb_multicycle_controller;
    import rv32_mc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] instret;
    logic [3:0]  state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic        illegal_insn;
`endif

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_instret;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .instret(instret),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_insn(illegal_insn),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == OP_RTYPE && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_ITYPE ||
               o == OP_BEQ || o == OP_JAL;
    endfunction

    // Runs one instruction starting at the mid-point of its FETCH cycle.
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] f3, input logic f7, input logic z);
        state_t     seq[$];
        int         lat;
        logic [4:0] exp_en;
        bit is_lw, is_sw, is_r, is_i, is_beq, is_jal;
        is_lw = (iop == OP_LW);   is_sw = (iop == OP_SW);
        is_r  = (iop == OP_RTYPE); is_i = (iop == OP_ITYPE);
        is_beq = (iop == OP_BEQ); is_jal = (iop == OP_JAL);
        seq = '{S_FETCH, S_DECODE};
        if (is_lw)  seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
        if (is_sw)  seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
        if (is_r)   seq = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
        if (is_i)   seq = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
        if (is_jal) seq = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
        if (is_beq) seq = '{S_FETCH, S_DECODE, S_BEQ};
        lat = seq.size();
        op = iop; funct3 = f3; funct7b5 = f7; zero = z;
        #1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            n_cmp++;
            if (state_o !== seq[cyc-1]) begin
                n_err++;
                $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", iop, cyc, state_o, seq[cyc-1]);
            end
            exp_en[4] = (cyc == 1) || (is_jal && cyc == 3) || (is_beq && cyc == 3 && z);
            exp_en[3] = (is_lw || is_sw) && cyc == 4;
            exp_en[2] = is_sw && cyc == 4;
            exp_en[1] = (cyc == 1);
            exp_en[0] = (is_lw || is_r || is_i || is_jal) && cyc == lat;
            n_cmp++;
            if ({pc_write, adr_src, mem_write, ir_write, reg_write} !== exp_en) begin
                n_err++;
                $display("FAIL enables op=%b cyc=%0d got=%b want=%b", iop, cyc,
                         {pc_write, adr_src, mem_write, ir_write, reg_write}, exp_en);
            end
            n_cmp++;
            if (imm_src !== ref_imm(iop)) begin
                n_err++;
                $display("FAIL imm_src op=%b got=%b want=%b", iop, imm_src, ref_imm(iop));
            end
            n_cmp++;
            if (instret !== exp_instret) begin
                n_err++;
                $display("FAIL instret_mid op=%b cyc=%0d got=%0d want=%0d", iop, cyc, instret, exp_instret);
            end
            if (cyc == 1) begin
                n_cmp++;
                if ({alu_src_a, alu_src_b, result_src, alu_control} !== {2'b00, 2'b10, 2'b10, 3'b000}) begin
                    n_err++;
                    $display("FAIL fetch_mux got=%b want=%b", {alu_src_a, alu_src_b, result_src, alu_control},
                             {2'b00, 2'b10, 2'b10, 3'b000});
                end
            end
            if (cyc == 3 && (is_r || is_i)) begin
                n_cmp++;
                if (alu_control !== ref_alu(iop, f3, f7)) begin
                    n_err++;
                    $display("FAIL alu_control op=%b f3=%b f7=%b got=%b want=%b", iop, f3, f7,
                             alu_control, ref_alu(iop, f3, f7));
                end
            end
            if (cyc == 3 && is_beq) begin
                n_cmp++;
                if (alu_control !== 3'b001) begin
                    n_err++;
                    $display("FAIL beq_alu got=%b want=001", alu_control);
                end
            end
            if (cyc == 5 && is_lw) begin
                n_cmp++;
                if (result_src !== 2'b01) begin
                    n_err++;
                    $display("FAIL lw_result_src got=%b want=01", result_src);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_instret = exp_instret + 32'd1;
        n_cmp++;
        if (instret !== exp_instret || state_o !== S_FETCH) begin
            n_err++;
            $display("FAIL retire op=%b instret=%0d want=%0d state=%0d want=%0d", iop, instret,
                     exp_instret, state_o, S_FETCH);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({state_o, instret, pc_write, ir_write, mem_write, reg_write} !==
                {4'd0, 32'd0, 4'b0000}) begin
                n_err++;
                $display("FAIL reset_hold state=%0d instret=%0d en=%b want state=0 instret=0 en=0000", state_o,
                         instret, {pc_write, ir_write, mem_write, reg_write});
            end
        end
        rst_n = 1'b1;
        exp_instret = 32'd0;
        #1;
        n_cmp++;
        if ({pc_write, ir_write, mem_write, reg_write} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_release en=%b want=1100", {pc_write, ir_write, mem_write, reg_write});
        end
    endtask

    task automatic test_reset_mid();
        op = OP_SW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (state_o !== S_MEMADR) begin
            n_err++;
            $display("FAIL mid_memadr state=%0d want=%0d", state_o, S_MEMADR);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (mem_write !== 1'b0) begin
                n_err++;
                $display("FAIL mid_mem_write got=%b want=0", mem_write);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (state_o !== S_FETCH || instret !== exp_instret || mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset state=%0d instret=%0d mw=%b want state=0 instret=%0d mw=0", state_o,
                     instret, mem_write, exp_instret);
        end
    endtask

    task automatic test_directed();
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0);
        n_cmp++;
        if (instret !== 32'd2) begin
            n_err++;
            $display("FAIL sw_lw_pair instret=%0d want=2", instret);
        end
        run_instr(OP_RTYPE, 3'b000, 1'b1, 1'b0);
        run_instr(OP_RTYPE, 3'b000, 1'b0, 1'b0);
        run_instr(OP_ITYPE, 3'b000, 1'b1, 1'b0);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] o;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL};
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 5)];
`ifndef MC_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                o = 7'($urandom_range(0, 127));
                while (is_legal(o)) o = 7'($urandom_range(0, 127));
            end
`endif
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        op = 7'b1111111;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({state_o, illegal_insn, pc_write, ir_write, mem_write, reg_write} !==
                {4'd11, 1'b1, 4'b0000} || instret !== exp_instret) begin
                n_err++;
                $display("FAIL trap state=%0d ill=%b en=%b instret=%0d want state=11 ill=1 en=0000 instret=%0d",
                         state_o, illegal_insn, {pc_write, ir_write, mem_write, reg_write}, instret, exp_instret);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 32'd0;
        n_cmp++;
        if (state_o !== S_FETCH || illegal_insn !== 1'b0 || instret !== 32'd0) begin
            n_err++;
            $display("FAIL trap_exit state=%0d ill=%b instret=%0d want 0/0/0", state_o, illegal_insn, instret);
        end
        run_instr(OP_ITYPE, 3'b111, 1'b0, 1'b0);
`else
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        clk = 1'b0;
        n_cmp = 0;
        n_err = 0;
        exp_instret = 32'd0;
        test_reset();
        test_reset_mid();
        test_directed();
        test_random();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
